// File: rtl/alu_sequencer.sv
// alu_sequencer: collects operand A, operand B and an opcode from one byte
// stream, drives them as registered operands into the combinational ALU,
// then captures the ALU result and offers it on a valid/ready output.
module alu_sequencer #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NB_DATA-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [NB_DATA-1:0] alu_d0,
    output logic [NB_DATA-1:0] alu_d1,
    output logic [NB_OP-1:0]   alu_opcode,
    input  logic [NB_DATA-1:0] alu_out,
    output logic [NB_DATA-1:0] res_data,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               err_op,
    output logic [7:0]         op_count
);

    localparam logic [2:0] LOAD_A  = 3'd0;
    localparam logic [2:0] LOAD_B  = 3'd1;
    localparam logic [2:0] LOAD_OP = 3'd2;
    localparam logic [2:0] EXEC    = 3'd3;
    localparam logic [2:0] RESULT  = 3'd4;

    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);

    logic [2:0]       state;
    logic             accept;
    logic [NB_OP-1:0] op_cand;

    // Only the opcodes the ALU actually implements are allowed through.
    function automatic logic is_legal(input logic [NB_OP-1:0] op);
        logic ok;
        case (op)
            NB_OP'(6'b100000),  // ADD
            NB_OP'(6'b100010),  // SUB
            NB_OP'(6'b100100),  // AND
            NB_OP'(6'b100101),  // OR
            NB_OP'(6'b100110),  // XOR
            NB_OP'(6'b000011),  // SRA
            NB_OP'(6'b000010),  // SRL
            NB_OP'(6'b100111):  // NOR
                ok = 1'b1;
            default:
                ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign op_cand = in_data[NB_OP-1:0];
    assign accept  = in_valid && in_ready;

    // Input is accepted only while one of the three load states is active.
    always_comb begin
        in_ready = (state == LOAD_A) || (state == LOAD_B) || (state == LOAD_OP);
    end

    // Sequencer state, operand/opcode registers, result capture and counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= LOAD_A;
            alu_d0     <= '0;
            alu_d1     <= '0;
            alu_opcode <= OP_ADD;
            res_data   <= '0;
            res_valid  <= 1'b0;
            err_op     <= 1'b0;
            op_count   <= 8'd0;
        end else begin
            err_op <= 1'b0;
            case (state)
                LOAD_A: begin
                    if (accept) begin
                        alu_d0 <= in_data;
                        state  <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        alu_d1 <= in_data;
                        state  <= LOAD_OP;
                    end
                end
                LOAD_OP: begin
                    // A rejected opcode keeps A/B so only the opcode is re-sent.
                    if (accept) begin
                        if (is_legal(op_cand)) begin
                            alu_opcode <= op_cand;
                            state      <= EXEC;
                        end else begin
                            err_op <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    // Operands have been stable since the opcode accept.
                    res_data  <= alu_out;
                    res_valid <= 1'b1;
                    op_count  <= op_count + 8'd1;
                    state     <= RESULT;
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= LOAD_A;
                    end
                end
                default: begin
                    state <= LOAD_A;
                end
            endcase
        end
    end

endmodule
